// File: rtl/rf_ctrl_pkg.sv
// Shared constants and FSM encoding for the register-file
// write-port controller.
package rf_ctrl_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int NUM_REGS  = 32;
  localparam int SWEEP_W   = $clog2(NUM_REGS) + 1;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr,
// scanning cyclically. Purely combinational.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] j;
  logic             hit;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    j   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NREQ);
      if (!hit && valid[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port sequencer with round-robin writeback.
// Define RF_INIT_SWEEP_EN to zero all registers after reset.
module rf_wb_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int DATA_W = RF_DATA_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_addr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   init_done,
  output logic [CNT_W-1:0]       conflict_cnt
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d, gidx;
  logic [NREQ-1:0]   gnt;
  logic [ADDR_W-1:0] sel_addr, addr_d;
  logic [DATA_W-1:0] sel_data, data_d;
  logic              we_d, xfer, multi;

`ifdef RF_INIT_SWEEP_EN
  logic [SWEEP_W-1:0] sweep_q, sweep_d;
`endif

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (ptr_q),
    .gnt   (gnt),
    .idx   (gidx)
  );

  // init_done is low in reset, so nothing is granted then
  assign req_ready = init_done ? gnt : '0;
  assign xfer      = |req_ready;
  assign multi     = $countones(req_valid) > 1;
  assign sel_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gidx*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef RF_INIT_SWEEP_EN
      state_q <= INIT;
      sweep_q <= '0;
`else
      state_q <= RUN;
`endif
    end else begin
      state_q <= state_d;
`ifdef RF_INIT_SWEEP_EN
      sweep_q <= sweep_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = rf_addr;
    data_d  = rf_wdata;
`ifdef RF_INIT_SWEEP_EN
    sweep_d = sweep_q;
`endif
    if (state_q == RUN) begin
      if (xfer) begin
        // x0 is accepted but never written
        we_d   = |sel_addr;
        addr_d = sel_addr;
        data_d = sel_data;
        ptr_d  = (gidx == IDX_W'(NREQ - 1)) ?
                 '0 : gidx + IDX_W'(1);
      end
    end
`ifdef RF_INIT_SWEEP_EN
    else if (sweep_q == SWEEP_W'(NUM_REGS)) begin
      state_d = RUN;
    end else begin
      we_d    = 1'b1;
      addr_d  = ADDR_W'(sweep_q);
      data_d  = '0;
      sweep_d = sweep_q + SWEEP_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we        <= 1'b0;
      rf_addr      <= '0;
      rf_wdata     <= '0;
      init_done    <= 1'b0;
      ptr_q        <= '0;
      conflict_cnt <= '0;
    end else begin
      rf_we     <= we_d;
      rf_addr   <= addr_d;
      rf_wdata  <= data_d;
      init_done <= (state_d == RUN);
      ptr_q     <= ptr_d;
      if (init_done && multi && !(&conflict_cnt))
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed requests,
// expected writes queued and checked by a write-port monitor.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_addr;
  logic [63:0] req_data;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic        init_done;
  logic [3:0]  conflict_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  always #5 clk = ~clk;

  rf_wb_arbiter #(
    .NREQ   (2),
    .ADDR_W (5),
    .DATA_W (32),
    .CNT_W  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .rf_we        (rf_we),
    .rf_addr      (rf_addr),
    .rf_wdata     (rf_wdata),
    .init_done    (init_done),
    .conflict_cnt (conflict_cnt)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic push(input logic [4:0] a,
                      input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_q.push_back(w);
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%0h want none",
                 rf_addr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 32'(rf_addr), 32'(mon_e.a));
        chk("wr_data", rf_wdata, mon_e.d);
      end
    end
  end

  task automatic cycle(input logic [1:0]  v,
                       input logic [4:0]  a0,
                       input logic [31:0] d0,
                       input logic [4:0]  a1,
                       input logic [31:0] d1,
                       input logic [1:0]  rdy,
                       input string       nm);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = {a1, a0};
    req_data  = {d1, d0};
    @(negedge clk);
    chk(nm, 32'(req_ready), 32'(rdy));
  endtask

  task automatic idle(input string nm);
    cycle(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, nm);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    req_data  = {32'h2, 32'h1};
    @(negedge clk);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_addr", 32'(rf_addr), 0);
    chk("rst_data", rf_wdata, 0);
    chk("rst_rdy", 32'(req_ready), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);
`ifdef RF_INIT_SWEEP_EN
    for (int i = 0; i < 32; i++) push(5'(i), 32'h0);
    #1 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      chk("sweep_done", 32'(init_done), 0);
      chk("sweep_rdy", 32'(req_ready), 0);
    end
    req_valid = 2'b00;
`else
    req_valid = 2'b00;
    #1 rst = 1'b0;
    chk("pre_edge_done", 32'(init_done), 0);
`endif
    @(negedge clk);
    chk("init_done", 32'(init_done), 1);
    chk("init_rdy", 32'(req_ready), 0);
    chk("init_cnt", 32'(conflict_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    do_reset();

    push(5'd5, 32'hDEADBEEF);
    cycle(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0,
          2'b01, "single_rdy");
    idle("single_idle");
    idle("hold_idle");
    chk("hold_we", 32'(rf_we), 0);
    chk("hold_addr", 32'(rf_addr), 5);
    chk("hold_data", rf_wdata, 32'hDEADBEEF);

    cycle(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234,
          2'b10, "x0_rdy");
    idle("x0_idle");
    chk("x0_we", 32'(rf_we), 0);

    push(5'd1, 32'hA0);
    cycle(2'b11, 5'd1, 32'hA0, 5'd1, 32'hB0, 2'b01, "cont0");
    push(5'd1, 32'hB0);
    cycle(2'b11, 5'd1, 32'hA1, 5'd1, 32'hB0, 2'b10, "cont1");
    push(5'd1, 32'hA1);
    cycle(2'b11, 5'd1, 32'hA1, 5'd1, 32'hB1, 2'b01, "cont2");
    push(5'd1, 32'hB1);
    cycle(2'b11, 5'd1, 32'hA2, 5'd1, 32'hB1, 2'b10, "cont3");
    push(5'd1, 32'hA2);
    cycle(2'b01, 5'd1, 32'hA2, 5'd0, 32'h0, 2'b01, "cont4");
    idle("cont_idle");
    chk("conflict4", 32'(conflict_cnt), 4);

    for (int k = 0; k < 20; k++) begin
      cycle(2'b11, 5'd0, 32'h0, 5'd0, 32'h0,
            (k % 2 == 0) ? 2'b10 : 2'b01, "sat_rdy");
      if (k == 10) chk("cnt_mid", 32'(conflict_cnt), 14);
    end
    idle("sat_idle");
    chk("cnt_sat", 32'(conflict_cnt), 15);

`ifdef RF_INIT_SWEEP_EN
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 11; i++) push(5'(i), 32'h0);
    #1 rst = 1'b0;
    repeat (11) @(negedge clk);
    chk("mid_addr10", 32'(rf_addr), 10);
    #1 rst = 1'b1;
    #1;
    chk("mid_we", 32'(rf_we), 0);
    chk("mid_addr", 32'(rf_addr), 0);
    chk("mid_done", 32'(init_done), 0);
`endif
    do_reset();

    push(5'd3, 32'hCAFEF00D);
    cycle(2'b11, 5'd3, 32'hCAFEF00D, 5'd4, 32'h55,
          2'b01, "post_rst_ptr");
    push(5'd4, 32'h55);
    cycle(2'b10, 5'd0, 32'h0, 5'd4, 32'h55,
          2'b10, "post_rst_r1");
    idle("tail0");
    idle("tail1");
    chk("post_cnt", 32'(conflict_cnt), 1);
    chk("drain", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
